// File: rtl/ads1292_spi_sequencer.sv
// rtl/ads1292_spi_sequencer.sv - ADS1292 command sequencer in front of spi_master
// Expands one command into its byte list, owns CS_N timing and assembles read data.
module ads1292_spi_sequencer #(
  parameter int CS_SETUP_CYCLES = 16,
  parameter int BYTE_GAP_CYCLES = 400,
  parameter int CS_HOLD_CYCLES  = 16
) (
  input  logic        i_CLK,
  input  logic        i_RST,
  input  logic        i_CMD_VALID,
  output logic        o_CMD_READY,
  input  logic [1:0]  i_CMD_TYPE,
  input  logic [7:0]  i_OPCODE,
  input  logic [4:0]  i_REG_ADDR,
  input  logic [7:0]  i_REG_WDATA,
  output logic        o_RD_VALID,
  output logic [7:0]  o_RD_DATA,
  output logic        o_FRAME_VALID,
  output logic [71:0] o_FRAME_DATA,
  output logic        o_BUSY,
  output logic        o_SPI_CS_N,
  output logic [7:0]  o_SPI_TX_BYTE,
  output logic        o_SPI_TX_DV,
  input  logic        i_SPI_TX_READY,
  input  logic        i_SPI_RX_DV,
  input  logic [7:0]  i_SPI_RX_BYTE
);
  localparam int MAX_P0 = (CS_SETUP_CYCLES > BYTE_GAP_CYCLES) ? CS_SETUP_CYCLES : BYTE_GAP_CYCLES;
  localparam int MAX_P  = (MAX_P0 > CS_HOLD_CYCLES) ? MAX_P0 : CS_HOLD_CYCLES;
  localparam int CNT_W  = (MAX_P < 1) ? 1 : $clog2(MAX_P + 1);
  // Gap and hold are measured from the RX_DV cycle itself, so their states last one cycle less.
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'((CS_SETUP_CYCLES >= 1) ? CS_SETUP_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'((BYTE_GAP_CYCLES >= 2) ? BYTE_GAP_CYCLES - 2 : 0);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'((CS_HOLD_CYCLES >= 2) ? CS_HOLD_CYCLES - 2 : 0);
  localparam logic [CNT_W-1:0] HIGH_LAST  = CNT_W'((CS_HOLD_CYCLES >= 1) ? CS_HOLD_CYCLES - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE, S_CS_SETUP, S_SEND, S_WAIT_RX, S_GAP, S_CS_HOLD, S_CS_HIGH
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [3:0]        idx_q, idx_d;
  logic [1:0]        type_q, type_d;
  logic [7:0]        opcode_q, opcode_d;
  logic [4:0]        addr_q, addr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic [7:0]        rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic [71:0]       frame_sr_q, frame_sr_d;
  logic [71:0]       frame_q, frame_d;
  logic              frame_valid_q, frame_valid_d;
  logic [3:0]        n_bytes;
  logic [3:0]        idx_inc;
  logic [7:0]        cur_byte;
  logic              tx_dv;
  logic [7:0]        tx_byte;

  always_comb begin
    case (type_q)
      2'd0:    n_bytes = 4'd1;
      2'd3:    n_bytes = 4'd9;
      default: n_bytes = 4'd3;
    endcase
  end

  always_comb begin
    cur_byte = 8'h00;
    case (type_q)
      2'd0: cur_byte = opcode_q;
      2'd1: begin
        if (idx_q == 4'd0)      cur_byte = {3'b010, addr_q};
        else if (idx_q == 4'd2) cur_byte = wdata_q;
      end
      2'd2: begin
        if (idx_q == 4'd0) cur_byte = {3'b001, addr_q};
      end
      default: cur_byte = 8'h00;
    endcase
  end

  assign idx_inc = idx_q + 4'd1;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    idx_d         = idx_q;
    type_d        = type_q;
    opcode_d      = opcode_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    rd_data_d     = rd_data_q;
    rd_valid_d    = 1'b0;
    frame_sr_d    = frame_sr_q;
    frame_d       = frame_q;
    frame_valid_d = 1'b0;
    tx_dv         = 1'b0;
    tx_byte       = 8'h00;
    case (state_q)
      S_IDLE: begin
        if (i_CMD_VALID) begin
          type_d     = i_CMD_TYPE;
          opcode_d   = i_OPCODE;
          addr_d     = i_REG_ADDR;
          wdata_d    = i_REG_WDATA;
          idx_d      = 4'd0;
          cnt_d      = '0;
          frame_sr_d = '0;
          state_d    = (CS_SETUP_CYCLES > 0) ? S_CS_SETUP : S_SEND;
        end
      end
      S_CS_SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          cnt_d   = '0;
          state_d = S_SEND;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_SEND: begin
        if (i_SPI_TX_READY) begin
          tx_dv   = 1'b1;
          tx_byte = cur_byte;
          state_d = S_WAIT_RX;
        end
      end
      S_WAIT_RX: begin
        if (i_SPI_RX_DV) begin
          idx_d = idx_inc;
          cnt_d = '0;
          if (type_q == 2'd2 && idx_q == 4'd2) rd_data_d = i_SPI_RX_BYTE;
          if (type_q == 2'd3) frame_sr_d = {frame_sr_q[63:0], i_SPI_RX_BYTE};
          if (idx_inc == n_bytes) begin
            // Published copy only changes at completion, so readers never see a partial frame.
            if (type_q == 2'd3) frame_d = {frame_sr_q[63:0], i_SPI_RX_BYTE};
            rd_valid_d    = (type_q == 2'd2);
            frame_valid_d = (type_q == 2'd3);
            state_d = (CS_HOLD_CYCLES >= 2) ? S_CS_HOLD :
                      (CS_HOLD_CYCLES >= 1) ? S_CS_HIGH : S_IDLE;
          end else begin
            state_d = (BYTE_GAP_CYCLES >= 2) ? S_GAP : S_SEND;
          end
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          state_d = S_SEND;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_CS_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          cnt_d   = '0;
          state_d = S_CS_HIGH;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_CS_HIGH: begin
        if (cnt_q == HIGH_LAST) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      idx_q         <= 4'd0;
      type_q        <= 2'd0;
      opcode_q      <= 8'h00;
      addr_q        <= 5'd0;
      wdata_q       <= 8'h00;
      rd_data_q     <= 8'h00;
      rd_valid_q    <= 1'b0;
      frame_sr_q    <= '0;
      frame_q       <= '0;
      frame_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      type_q        <= type_d;
      opcode_q      <= opcode_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      rd_data_q     <= rd_data_d;
      rd_valid_q    <= rd_valid_d;
      frame_sr_q    <= frame_sr_d;
      frame_q       <= frame_d;
      frame_valid_q <= frame_valid_d;
    end
  end

  assign o_CMD_READY   = (state_q == S_IDLE);
  assign o_BUSY        = (state_q != S_IDLE);
  assign o_SPI_CS_N    = (state_q == S_IDLE) || (state_q == S_CS_HIGH);
  assign o_SPI_TX_DV   = tx_dv;
  assign o_SPI_TX_BYTE = tx_byte;
  assign o_RD_VALID    = rd_valid_q;
  assign o_RD_DATA     = rd_data_q;
  assign o_FRAME_VALID = frame_valid_q;
  assign o_FRAME_DATA  = frame_q;

endmodule

// File: tb/tb_ads1292_spi_sequencer.sv
// tb/tb_ads1292_spi_sequencer.sv - self-checking bench for ads1292_spi_sequencer
// A behavioural spi_master answers TX_DV with RX_DV; a scoreboard checks MOSI and read results.
module tb_ads1292_spi_sequencer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_type = 2'd0;
  logic [7:0]  opcode = 8'h00;
  logic [4:0]  reg_addr = 5'd0;
  logic [7:0]  reg_wdata = 8'h00;
  logic        rd_valid;
  logic [7:0]  rd_data;
  logic        frame_valid;
  logic [71:0] frame_data;
  logic        busy;
  logic        cs_n;
  logic [7:0]  tx_byte;
  logic        tx_dv;
  logic        spi_ready = 1'b1;
  logic        rx_dv = 1'b0;
  logic [7:0]  rx_byte = 8'h00;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [7:0]  miso_q[$];
  logic [7:0]  mosi_exp_q[$];
  int          exp_kind_q[$];
  logic [71:0] exp_data_q[$];

  int busy_cnt = 0;
  int tx_count = 0, rd_pulses = 0, frame_pulses = 0, bad_dv = 0;
  int cs_rises = 0, cs_falls = 0;
  int cs_rise_cyc = 0, cs_fall_cyc = 0, ready_rise_cyc = 0;
  int last_rx_cyc = 0, last_tx_cyc = 0, rd_valid_cyc = 0;
  int min_gap = 1000000;
  bit have_rx = 1'b0;
  logic prev_cs_n = 1'b1, prev_ready = 1'b0;

  ads1292_spi_sequencer dut (
    .i_CLK(clk), .i_RST(rst),
    .i_CMD_VALID(cmd_valid), .o_CMD_READY(cmd_ready),
    .i_CMD_TYPE(cmd_type), .i_OPCODE(opcode), .i_REG_ADDR(reg_addr), .i_REG_WDATA(reg_wdata),
    .o_RD_VALID(rd_valid), .o_RD_DATA(rd_data),
    .o_FRAME_VALID(frame_valid), .o_FRAME_DATA(frame_data),
    .o_BUSY(busy), .o_SPI_CS_N(cs_n),
    .o_SPI_TX_BYTE(tx_byte), .o_SPI_TX_DV(tx_dv), .i_SPI_TX_READY(spi_ready),
    .i_SPI_RX_DV(rx_dv), .i_SPI_RX_BYTE(rx_byte)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // spi_master stand-in plus output monitor; everything happens on the falling edge
  task automatic bus_model();
    logic [7:0]  eb;
    logic [71:0] ed;
    int          ek;
    forever begin
      @(negedge clk);
      if (cs_n && !prev_cs_n) begin cs_rise_cyc = cyc; cs_rises++; end
      if (!cs_n && prev_cs_n) begin cs_fall_cyc = cyc; cs_falls++; end
      if (cmd_ready && !prev_ready) ready_rise_cyc = cyc;
      prev_cs_n  = cs_n;
      prev_ready = cmd_ready;
      if (rd_valid) begin
        rd_pulses++;
        rd_valid_cyc = cyc;
        checks++;
        if (exp_kind_q.size() == 0) begin
          errors++; $display("FAIL rd_valid_unexpected got=%h", rd_data);
        end else begin
          ek = exp_kind_q.pop_front(); ed = exp_data_q.pop_front();
          if (ek != 2 || rd_data !== ed[7:0]) begin
            errors++; $display("FAIL rd_data got=%h kind=%0d want=%h", rd_data, ek, ed[7:0]);
          end
        end
      end
      if (frame_valid) begin
        frame_pulses++;
        checks++;
        if (exp_kind_q.size() == 0) begin
          errors++; $display("FAIL frame_valid_unexpected got=%h", frame_data);
        end else begin
          ek = exp_kind_q.pop_front(); ed = exp_data_q.pop_front();
          if (ek != 3 || frame_data !== ed) begin
            errors++; $display("FAIL frame_data got=%h kind=%0d want=%h", frame_data, ek, ed);
          end
        end
      end
      if (tx_dv) begin
        if (!spi_ready) bad_dv++;
        tx_count++;
        if (have_rx && (cyc - last_rx_cyc) < min_gap) min_gap = cyc - last_rx_cyc;
        last_tx_cyc = cyc;
        checks++;
        if (mosi_exp_q.size() == 0) begin
          errors++; $display("FAIL mosi_unexpected got=%h", tx_byte);
        end else begin
          eb = mosi_exp_q.pop_front();
          if (tx_byte !== eb) begin
            errors++; $display("FAIL mosi_byte got=%h want=%h", tx_byte, eb);
          end
        end
      end
      if (rst) begin
        spi_ready = 1'b1; rx_dv = 1'b0; busy_cnt = 0; have_rx = 1'b0;
        miso_q.delete(); mosi_exp_q.delete();
      end else begin
        rx_dv = 1'b0;
        if (tx_dv) begin
          busy_cnt = 8;
        end else if (busy_cnt > 0) begin
          spi_ready = 1'b0;
          busy_cnt--;
          if (busy_cnt == 0) begin
            rx_dv = 1'b1;
            spi_ready = 1'b1;
            rx_byte = (miso_q.size() != 0) ? miso_q.pop_front() : 8'h00;
            last_rx_cyc = cyc;
            have_rx = 1'b1;
          end
        end
      end
      if (cs_n) have_rx = 1'b0;
    end
  endtask

  initial bus_model();

  task automatic send_cmd(input logic [1:0] t, input logic [7:0] op,
                          input logic [4:0] a, input logic [7:0] wd);
    int n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 20000) begin @(negedge clk); n++; end
    checks++;
    if (!cmd_ready) begin
      errors++; $display("FAIL cmd_accept_timeout ready=%b want=1", cmd_ready);
      return;
    end
    cmd_valid = 1'b1; cmd_type = t; opcode = op; reg_addr = a; reg_wdata = wd;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!cmd_ready && n < 20000) begin @(negedge clk); n++; end
    checks++;
    if (!cmd_ready) begin errors++; $display("FAIL idle_timeout ready=%b want=1", cmd_ready); end
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (cs_n !== 1'b1)       begin errors++; $display("FAIL rst_cs_n got=%b want=1", cs_n); end
    checks++; if (tx_dv !== 1'b0)      begin errors++; $display("FAIL rst_tx_dv got=%b want=0", tx_dv); end
    checks++; if (tx_byte !== 8'h00)   begin errors++; $display("FAIL rst_tx_byte got=%h want=00", tx_byte); end
    checks++; if (cmd_ready !== 1'b1)  begin errors++; $display("FAIL rst_ready got=%b want=1", cmd_ready); end
    checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL rst_busy got=%b want=0", busy); end
    checks++; if (rd_valid !== 1'b0 || frame_valid !== 1'b0) begin
      errors++; $display("FAIL rst_valids got=%b%b want=00", rd_valid, frame_valid); end
    checks++; if (rd_data !== 8'h00 || frame_data !== 72'h0) begin
      errors++; $display("FAIL rst_data got=%h/%h want=0", rd_data, frame_data); end
  endtask

  task automatic test_wreg();
    int t0 = tx_count, r0 = rd_pulses, f0 = frame_pulses, cr0 = cs_rises, cf0 = cs_falls;
    min_gap = 1000000;
    mosi_exp_q = '{8'h41, 8'h00, 8'h02};
    send_cmd(2'd1, 8'h00, 5'h01, 8'h02);
    wait_idle();
    checks++; if (tx_count - t0 != 3) begin errors++; $display("FAIL wreg_tx_count got=%0d want=3", tx_count - t0); end
    checks++; if (cs_rises - cr0 != 1 || cs_falls - cf0 != 1) begin
      errors++; $display("FAIL wreg_cs_continuous rises=%0d falls=%0d want=1/1", cs_rises - cr0, cs_falls - cf0); end
    checks++; if (min_gap < 400) begin errors++; $display("FAIL wreg_gap got=%0d want>=400", min_gap); end
    checks++; if (rd_pulses != r0 || frame_pulses != f0) begin
      errors++; $display("FAIL wreg_no_valid rd=%0d frame=%0d want=0/0", rd_pulses - r0, frame_pulses - f0); end
    checks++; if (mosi_exp_q.size() != 0) begin errors++; $display("FAIL wreg_mosi_left got=%0d want=0", mosi_exp_q.size()); end
  endtask

  task automatic test_rreg(input logic [7:0] val);
    int r0 = rd_pulses;
    mosi_exp_q = '{8'h20, 8'h00, 8'h00};
    miso_q = '{8'hA5, 8'h5A, val};
    exp_kind_q.push_back(2); exp_data_q.push_back({64'h0, val});
    send_cmd(2'd2, 8'h00, 5'h00, 8'h00);
    wait_idle();
    checks++; if (rd_pulses - r0 != 1) begin errors++; $display("FAIL rreg_pulses got=%0d want=1", rd_pulses - r0); end
    checks++; if (rd_valid_cyc - last_rx_cyc != 1) begin
      errors++; $display("FAIL rreg_valid_latency got=%0d want=1", rd_valid_cyc - last_rx_cyc); end
    checks++; if (rd_data !== val) begin errors++; $display("FAIL rreg_data_stable got=%h want=%h", rd_data, val); end
    checks++; if (exp_kind_q.size() != 0 || mosi_exp_q.size() != 0) begin
      errors++; $display("FAIL rreg_scoreboard_left got=%0d/%0d want=0/0", exp_kind_q.size(), mosi_exp_q.size()); end
  endtask

  task automatic test_rdata();
    int f0 = frame_pulses;
    mosi_exp_q = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    miso_q = '{8'hC0, 8'h00, 8'h00, 8'h12, 8'h34, 8'h56, 8'hAB, 8'hCD, 8'hEF};
    exp_kind_q.push_back(3); exp_data_q.push_back(72'hC00000123456ABCDEF);
    send_cmd(2'd3, 8'h00, 5'h00, 8'h00);
    wait_idle();
    checks++; if (frame_pulses - f0 != 1) begin errors++; $display("FAIL rdata_pulses got=%0d want=1", frame_pulses - f0); end
    checks++; if (frame_data !== 72'hC00000123456ABCDEF) begin
      errors++; $display("FAIL rdata_stable got=%h want=C00000123456ABCDEF", frame_data); end
    checks++; if (exp_kind_q.size() != 0 || mosi_exp_q.size() != 0) begin
      errors++; $display("FAIL rdata_scoreboard_left got=%0d/%0d want=0/0", exp_kind_q.size(), mosi_exp_q.size()); end
  endtask

  task automatic test_opcode();
    int t0 = tx_count;
    mosi_exp_q = '{8'h08};
    send_cmd(2'd0, 8'h08, 5'h00, 8'h00);
    wait_idle();
    checks++; if (tx_count - t0 != 1) begin errors++; $display("FAIL op_tx_count got=%0d want=1", tx_count - t0); end
    checks++; if (last_tx_cyc - cs_fall_cyc != 16) begin
      errors++; $display("FAIL op_cs_setup got=%0d want=16", last_tx_cyc - cs_fall_cyc); end
    checks++; if (cs_rise_cyc - last_rx_cyc != 16) begin
      errors++; $display("FAIL op_cs_hold got=%0d want=16", cs_rise_cyc - last_rx_cyc); end
    checks++; if (ready_rise_cyc - cs_rise_cyc != 16) begin
      errors++; $display("FAIL op_cs_high got=%0d want=16", ready_rise_cyc - cs_rise_cyc); end
  endtask

  task automatic test_back_to_back();
    int t0 = tx_count;
    int n = 0;
    mosi_exp_q = '{8'h0A, 8'h0B};
    @(negedge clk);
    cmd_valid = 1'b1; cmd_type = 2'd0; opcode = 8'h0A;
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_first_accept busy=%b want=1", busy); end
    opcode = 8'h0B;
    while (!cmd_ready && n < 20000) begin @(negedge clk); n++; end
    checks++; if (cs_n !== 1'b1 || ready_rise_cyc - cs_rise_cyc != 16) begin
      errors++; $display("FAIL b2b_ready_after_cs_high cs_n=%b gap=%0d want=1/16", cs_n, ready_rise_cyc - cs_rise_cyc); end
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_second_accept busy=%b want=1", busy); end
    cmd_valid = 1'b0;
    repeat (5) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      cmd_valid = 1'b1; opcode = 8'h0C;
      @(negedge clk);
      cmd_valid = 1'b0;
      repeat (20) @(negedge clk);
    end
    wait_idle();
    repeat (40) @(negedge clk);
    checks++; if (tx_count - t0 != 2) begin errors++; $display("FAIL b2b_tx_count got=%0d want=2", tx_count - t0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_phantom busy=%b want=0", busy); end
  endtask

  task automatic test_reset_mid_frame();
    int t0 = tx_count, f0 = frame_pulses;
    int n = 0;
    mosi_exp_q = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    miso_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99};
    send_cmd(2'd3, 8'h00, 5'h00, 8'h00);
    while (tx_count - t0 < 4 && n < 20000) begin @(negedge clk); n++; end
    checks++; if (tx_count - t0 < 4) begin errors++; $display("FAIL midrst_reach_byte4 got=%0d want=4", tx_count - t0); end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (cs_n !== 1'b1 || tx_dv !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++; $display("FAIL midrst_state cs_n=%b tx_dv=%b busy=%b ready=%b want=1/0/0/1", cs_n, tx_dv, busy, cmd_ready); end
    @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    checks++; if (frame_pulses != f0) begin errors++; $display("FAIL midrst_no_frame got=%0d want=0", frame_pulses - f0); end
    test_rreg(8'h5A);
  endtask

  initial begin
    test_reset();
    test_wreg();
    test_rreg(8'h73);
    test_rdata();
    test_opcode();
    test_back_to_back();
    test_reset_mid_frame();
    checks++; if (bad_dv != 0) begin errors++; $display("FAIL tx_dv_while_not_ready got=%0d want=0", bad_dv); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50ms;
    $display("FAIL global_timeout cyc=%0d want=finish", cyc);
    $fatal(1, "timeout");
  end
endmodule
